// File: rtl/clock_divider_gen_pkg.sv
// clock_divider_gen_pkg: shared state encoding and divisor limits for clock_divider_gen
package clock_divider_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int unsigned DIV_MIN = 1;
  function automatic int unsigned div_clamp(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction
endpackage

// File: rtl/clock_divider_gen_half_period_counter.sv
// half_period_counter: loadable down-counter with zero flag, saturating at 0
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_load, i_load_val : load request and value (load wins over decrement)
//   i_dec              : decrement enable
//   o_zero             : counter is zero
module half_period_counter
  import clock_divider_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/clock_divider_gen.sv
// clock_divider_gen: programmable 50%-duty clock divider with edge strobes and glitch-free start/stop
//   CLK50MHZ, RST            : system clock, synchronous active-low reset
//   en                       : run request
//   div_half                 : half-period in CLK50MHZ cycles (0 treated as 1)
//   clk_div                  : divided clock
//   clk_div_rise/fall/trig2x : registered edge strobes, valid alongside clk_div
//   busy                     : high while running or finishing the last period
//   Optional (CLOCK_DIVIDER_GEN_BURST_EN): burst_len, burst_go in; burst_done out
module clock_divider_gen
  import clock_divider_gen_pkg::*;
#(
  parameter int   CNT_W      = 16,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   DIV_RST    = 25
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic             en,
  input  logic [CNT_W-1:0] div_half,
`ifdef CLOCK_DIVIDER_GEN_BURST_EN
  input  logic [CNT_W-1:0] burst_len,
  input  logic             burst_go,
  output logic             burst_done,
`endif
  output logic             clk_div,
  output logic             clk_div_rise,
  output logic             clk_div_fall,
  output logic             clk_div_trig2x,
  output logic             busy
);
  localparam logic [CNT_W-1:0] D_RST = CNT_W'(div_clamp(DIV_RST));
  state_t           r_state, w_state_nxt;
  logic             r_clk, r_rise, r_fall, r_trig;
  logic [CNT_W-1:0] r_div, w_d_in, w_load_val;
  logic             w_zero, w_running, w_toggle, w_boundary, w_relatch, w_load, w_start, w_keep;
`ifdef CLOCK_DIVIDER_GEN_BURST_EN
  logic             r_burst, r_done, w_more;
  logic [CNT_W-1:0] r_bcnt;
  assign w_more  = r_burst && (r_bcnt > CNT_W'(1));
  assign w_start = (r_state == IDLE) && (en || (burst_go && burst_len != '0));
  assign w_keep  = en || w_more;
`else
  assign w_start = (r_state == IDLE) && en;
  assign w_keep  = en;
`endif
  half_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk      (CLK50MHZ),
    .i_rst_n    (RST),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_running),
    .o_zero     (w_zero)
  );
  // A boundary is the toggle that returns clk_div to the idle level; only there
  // (and at start) is the divisor re-latched, so no period is ever shortened.
  always_comb begin
    w_running   = (r_state != IDLE);
    w_toggle    = w_running && w_zero;
    w_boundary  = w_toggle && (r_clk != IDLE_LEVEL);
    w_relatch   = w_start || w_boundary;
    w_d_in      = (div_half == '0) ? CNT_W'(DIV_MIN) : div_half;
    w_load      = w_relatch || w_toggle;
    w_load_val  = (w_relatch ? w_d_in : r_div) - CNT_W'(1);
    w_state_nxt = !w_running ? (w_start ? RUN : IDLE) :
                  (w_boundary && !w_keep) ? IDLE :
                  w_keep ? RUN : STOP;
  end
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      r_clk  <= IDLE_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_trig <= 1'b0;
      r_div  <= D_RST;
    end else begin
      r_clk  <= r_clk ^ w_toggle;
      r_rise <= w_toggle && !r_clk;
      r_fall <= w_toggle && r_clk;
      r_trig <= w_toggle;
      r_div  <= w_relatch ? w_d_in : r_div;
    end
  end
`ifdef CLOCK_DIVIDER_GEN_BURST_EN
  // r_bcnt counts remaining full periods; a zero-length burst finishes without starting.
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      r_burst <= 1'b0;
      r_done  <= 1'b0;
      r_bcnt  <= '0;
    end else begin
      r_done  <= (r_burst && w_boundary && !w_keep) ||
                 ((r_state == IDLE) && burst_go && !en && burst_len == '0);
      r_bcnt  <= ((r_state == IDLE) && burst_go) ? burst_len :
                 (w_boundary && r_bcnt != '0) ? r_bcnt - CNT_W'(1) : r_bcnt;
      r_burst <= (r_state == IDLE) ? (burst_go && burst_len != '0) :
                 (r_burst && !(w_boundary && !w_more));
    end
  end
  assign burst_done = r_done;
`endif
  assign clk_div        = r_clk;
  assign clk_div_rise   = r_rise;
  assign clk_div_fall   = r_fall;
  assign clk_div_trig2x = r_trig;
  assign busy           = w_running;
endmodule

// File: tb/tb_clock_divider_gen.sv
// tb_clock_divider_gen: randomized self-checking bench against a timestamp-based reference model
module tb_clock_divider_gen;
  localparam int   CNT_W = 16;
  localparam logic IL    = 1'b0;
  logic CLK50MHZ = 1'b0, RST = 1'b0, en = 1'b0;
  logic [CNT_W-1:0] div_half = 16'd25;
  logic clk_div, clk_div_rise, clk_div_fall, clk_div_trig2x, busy;
`ifdef CLOCK_DIVIDER_GEN_BURST_EN
  logic [CNT_W-1:0] burst_len = '0;
  logic burst_go = 1'b0, burst_done;
`endif
  int n_checks = 0, n_fail = 0, t = 0;
  int n_rise = 0, n_fall = 0;
  bit m_run = 0, m_lvl = IL, m_rise = 0, m_fall = 0;
  int m_d = 25, m_next = 0;

  clock_divider_gen #(.CNT_W(CNT_W), .IDLE_LEVEL(IL), .DIV_RST(25)) dut (
    .CLK50MHZ       (CLK50MHZ),
    .RST            (RST),
    .en             (en),
    .div_half       (div_half),
`ifdef CLOCK_DIVIDER_GEN_BURST_EN
    .burst_len      (burst_len),
    .burst_go       (burst_go),
    .burst_done     (burst_done),
`endif
    .clk_div        (clk_div),
    .clk_div_rise   (clk_div_rise),
    .clk_div_fall   (clk_div_fall),
    .clk_div_trig2x (clk_div_trig2x),
    .busy           (busy)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, t);
    end
  endtask

  // Reference: the output is a sequence of toggles at absolute edge times; the
  // next toggle is always one latched half-period after the previous one.
  task automatic model(input bit r, input bit e, input int dh);
    m_rise = 0;
    m_fall = 0;
    if (!r) begin
      m_run = 0;
      m_lvl = IL;
      m_d   = 25;
    end else if (!m_run) begin
      if (e) begin
        m_run  = 1;
        m_d    = (dh < 1) ? 1 : dh;
        m_next = t + m_d;
      end
    end else if (t == m_next) begin
      m_lvl  = !m_lvl;
      m_rise = m_lvl;
      m_fall = !m_lvl;
      if (m_lvl == IL) begin
        m_d = (dh < 1) ? 1 : dh;
        if (!e) m_run = 0;
      end
      m_next = t + m_d;
    end
  endtask

  task automatic step(input bit r, input bit e, input int dh);
    RST = r;
    en = e;
    div_half = dh[CNT_W-1:0];
    @(posedge CLK50MHZ);
    t++;
    model(r, e, dh);
    #1;
    check("clk_div", clk_div, m_lvl);
    check("rise", clk_div_rise, m_rise);
    check("fall", clk_div_fall, m_fall);
    check("trig2x", clk_div_trig2x, m_rise | m_fall);
    check("busy", busy, m_run);
    if (clk_div_rise) n_rise++;
    if (clk_div_fall) n_fall++;
  endtask

`ifdef CLOCK_DIVIDER_GEN_BURST_EN
  task automatic bstep(input bit go, input int len);
    RST = 1;
    en = 0;
    div_half = 16'd2;
    burst_go = go;
    burst_len = len[CNT_W-1:0];
    @(posedge CLK50MHZ);
    t++;
    #1;
  endtask
`endif

  initial begin
    int rt, ft, nf, last_tog, e, dh;
    logic prev;
    step(0, 0, 25);
    step(0, 0, 25);
    repeat (100) step(1, 0, 25);
    n_rise = 0;
    n_fall = 0;
    repeat (525) step(1, 1, 25);
    check("rise_cnt_525", n_rise, 10);
    check("fall_cnt_525", n_fall, 10);
    for (int i = 0; i < 60 && !clk_div; i++) step(1, 1, 25);
    check("wait_high", clk_div, 1);
    last_tog = t;
    prev = clk_div;
    repeat (5) step(1, 1, 25);
    for (int i = 0; i < 80; i++) begin
      step(1, 1, 5);
      if (clk_div !== prev) begin
        check("pulse_min", (t - last_tog) >= 5, 1);
        last_tog = t;
        prev = clk_div;
      end
    end
    repeat (12) step(1, 1, 25);
    n_rise = 0;
    for (int i = 0; i < 60 && n_rise == 0; i++) step(1, 1, 25);
    check("wait_rise", n_rise, 1);
    rt = t;
    step(1, 1, 25);
    step(1, 1, 25);
    nf = 0;
    ft = 0;
    n_rise = 0;
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 25);
      if (clk_div_fall) begin
        nf++;
        ft = t;
      end
    end
    check("stop_fall_cnt", nf, 1);
    check("stop_delay", ft - rt, 25);
    check("stop_no_rise", n_rise, 0);
    check("stop_busy", busy, 0);
    for (int d = 0; d < 2; d++) begin
      step(1, 1, d);
      step(1, 1, d);
      repeat (10) begin
        step(1, 1, d);
        check("trig_hi", clk_div_trig2x, 1);
      end
      repeat (6) step(1, 0, d);
      check("d_small_idle", busy, 0);
    end
    for (int i = 0; i < 30 && !clk_div; i++) step(1, 1, 7);
    check("wait_high2", clk_div, 1);
    step(0, 1, 7);
    check("rst_clk", clk_div, 0);
    check("rst_busy", busy, 0);
    check("rst_trig", clk_div_trig2x, 0);
    repeat (3) step(1, 0, 7);
    e = 0;
    dh = 3;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) e = !e;
      if ($urandom_range(0, 29) == 0) dh = $urandom_range(0, 12);
      step($urandom_range(0, 299) != 0, e[0], dh);
    end
    repeat (40) step(1, 0, 3);
`ifdef CLOCK_DIVIDER_GEN_BURST_EN
    begin
      int nr, nd, df;
      nr = 0;
      nd = 0;
      df = 0;
      bstep(1, 3);
      for (int i = 0; i < 40; i++) begin
        bstep(0, 3);
        if (clk_div_rise) nr++;
        if (burst_done) begin
          nd++;
          df = clk_div_fall;
        end
      end
      check("burst_rises", nr, 3);
      check("burst_done_cnt", nd, 1);
      check("burst_done_fall", df, 1);
      check("burst_idle", busy, 0);
      bstep(1, 0);
      check("burst0_done", burst_done, 1);
      check("burst0_busy", busy, 0);
      bstep(0, 0);
      check("burst0_once", burst_done, 0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
